// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with pixel-enable divider; clk/rst in, rgb_in colour in, hCount/vCount/bright/pix_en/frame_tick timing out, hSync/vSync/vgaR/G/B pins out
module vga_timing_gen #(
  parameter int DIV         = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  logic [DW-1:0] div;
  logic [9:0] h_nxt, v_nxt;
  logic h_wrap, v_last;
  always_comb begin
    h_wrap = hCount == 10'(H_TOTAL - 1);
    v_last = vCount == 10'(V_TOTAL - 1);
    h_nxt  = h_wrap ? '0 : hCount + 10'd1;
    v_nxt  = !h_wrap ? vCount : v_last ? '0 : vCount + 10'd1;
  end
  assign frame_tick = pix_en && h_wrap && v_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      pix_en <= 1'b0;
      hCount <= '0;
      vCount <= '0;
      bright <= 1'b0;
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      {vgaR, vgaG, vgaB} <= '0;
    end else begin
      div    <= (div == DW'(DIV - 1)) ? '0 : div + DW'(1);
      pix_en <= div == DW'(DIV - 1);
      if (pix_en) begin
        hCount <= h_nxt;
        vCount <= v_nxt;
        bright <= h_nxt >= 10'(H_VIS_START) && h_nxt <= 10'(H_VIS_END) &&
                  v_nxt >= 10'(V_VIS_START) && v_nxt <= 10'(V_VIS_END);
        hSync  <= hCount >= 10'(H_SYNC);
        vSync  <= vCount >= 10'(V_SYNC);
        {vgaR, vgaG, vgaB} <= bright ? rgb_in : '0;
      end
    end
  end
endmodule
